inst_load_ctrl: RTL and testbench

Boot-time controller for the instruction memory behind `inst_fetch`. It accepts the program image as a byte stream from the serial receiver, assembles big-endian 32-bit words, writes them to consecutive instruction-memory addresses, then releases the core and hands the memory port to the fetch stage. Until the load completes, fetch is stalled and memory writes come only from this block.

---
 rtl/inst_load_pkg.sv | 16 +
 rtl/inst_load_ctrl_byte_assembler.sv | 32 +++
 rtl/inst_load_ctrl.sv | 145 ++++++++++++++
 tb/tb_inst_load_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_load_pkg.sv
// rtl/inst_load_pkg.sv - shared types and constants for the instruction-memory boot loader
package inst_load_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 4;
    localparam int CSUM_BYTES     = 4;

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } load_state_t;

endpackage

// File: rtl/inst_load_ctrl_byte_assembler.sv
// rtl/inst_load_ctrl_byte_assembler.sv - packs big-endian bytes into 32-bit words
module byte_assembler
    import inst_load_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_word_valid,
    output logic [31:0] o_word_data
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_byte_valid) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= {r_shift[15:0], i_byte_data};
        end
    end

    // The completing byte bypasses the register so the word is visible in its arrival cycle.
    assign o_word_valid = i_byte_valid && (r_idx == LAST_IDX);
    assign o_word_data  = {r_shift, i_byte_data};

endmodule

// File: rtl/inst_load_ctrl.sv
// rtl/inst_load_ctrl.sv - boot loader writing a byte-streamed image into instruction memory
// Optional trailing checksum check: INST_LOAD_CHECKSUM_EN
module inst_load_ctrl
    import inst_load_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 14
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    input  logic                      fetch_req,
    input  logic [INST_MEM_WIDTH-1:0] fetch_addr,
    output logic                      fetch_grant,
    output logic                      mem_we,
    output logic [INST_MEM_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    output logic                      cpu_run,
    output logic                      load_err,
    output logic [INST_MEM_WIDTH:0]   words_loaded
);

    localparam int          W         = INST_MEM_WIDTH;
    localparam logic [32:0] MAX_WORDS = 33'd1 << W;
    localparam logic [W:0]  ONE       = 1;

    load_state_t     r_state;
    load_state_t     w_state_next;
    logic [W:0]      r_count;
    logic [W:0]      r_words_loaded;
    logic            r_mem_we;
    logic [W-1:0]    r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic            r_load_err;
`ifdef INST_LOAD_CHECKSUM_EN
    logic [31:0]     r_sum;
`endif

    logic            w_byte_acc;
    logic            w_word_valid;
    logic [31:0]     w_word;
    logic            w_last_word;
    logic            w_run;
    logic            w_asm_clr;

    assign rx_ready    = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_byte_acc  = rx_valid && rx_ready;
    assign w_last_word = (r_words_loaded + ONE) == r_count;
    assign w_asm_clr   = !reset || (w_state_next != r_state);

    byte_assembler u_asm (
        .i_clk        (CLK),
        .i_clr        (w_asm_clr),
        .i_byte_valid (w_byte_acc),
        .i_byte_data  (rx_data),
        .o_word_valid (w_word_valid),
        .o_word_data  (w_word)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HDR: begin
                if (w_word_valid) begin
                    if (w_word == 32'd0) begin
`ifdef INST_LOAD_CHECKSUM_EN
                        w_state_next = ST_CSUM;
`else
                        w_state_next = ST_RUN;
`endif
                    end else if ({1'b0, w_word} > MAX_WORDS) begin
                        w_state_next = ST_ERR;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_word_valid && w_last_word) begin
`ifdef INST_LOAD_CHECKSUM_EN
                    w_state_next = ST_CSUM;
`else
                    w_state_next = ST_RUN;
`endif
                end
            end
`ifdef INST_LOAD_CHECKSUM_EN
            ST_CSUM: begin
                if (w_word_valid) begin
                    w_state_next = (w_word == r_sum) ? ST_RUN : ST_ERR;
                end
            end
`endif
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state        <= ST_HDR;
            r_count        <= '0;
            r_words_loaded <= '0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_load_err     <= 1'b0;
`ifdef INST_LOAD_CHECKSUM_EN
            r_sum          <= '0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_mem_we <= 1'b0;
            if (w_word_valid && (r_state == ST_HDR)) begin
                r_count <= w_word[W:0];
`ifdef INST_LOAD_CHECKSUM_EN
                r_sum   <= w_word;
`endif
            end
            if (w_word_valid && (r_state == ST_DATA)) begin
                r_mem_we       <= 1'b1;
                r_mem_addr     <= r_words_loaded[W-1:0];
                r_mem_wdata    <= w_word;
                r_words_loaded <= r_words_loaded + ONE;
`ifdef INST_LOAD_CHECKSUM_EN
                r_sum          <= r_sum + w_word;
`endif
            end
            if (w_state_next == ST_ERR) begin
                r_load_err <= 1'b1;
            end
        end
    end

    // The core is held back while the final write is still leaving the pipeline.
    assign w_run        = (r_state == ST_RUN) && !r_mem_we;
    assign cpu_run      = w_run;
    assign fetch_grant  = w_run && fetch_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = w_run ? fetch_addr : r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign load_err     = r_load_err;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_inst_load_ctrl.sv
// tb/tb_inst_load_ctrl.sv - directed self-checking bench for inst_load_ctrl
module tb_inst_load_ctrl;

`ifdef INST_LOAD_CHECKSUM_EN
    localparam int RUN_LAT = 4;
`else
    localparam int RUN_LAT = 1;
`endif

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        fetch_req = 1'b0;
    logic [13:0] fetch_addr = 14'd0;

    logic        rx_ready, fetch_grant, mem_we, cpu_run, load_err;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [14:0] words_loaded;

    logic        b_rx_ready, b_fetch_grant, b_mem_we, b_cpu_run, b_load_err;
    logic [1:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [2:0]  b_words_loaded;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [13:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          last_wr_cyc = 0;
    int          run_cyc = 0;
    bit          run_seen = 1'b0;
    int          grant_bad = 0;
    logic [31:0] img[$];
    logic [31:0] exp_data[$];

    always #5 CLK = ~CLK;

    inst_load_ctrl #(.INST_MEM_WIDTH(14)) u_dut (
        .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_grant(fetch_grant),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .load_err(load_err), .words_loaded(words_loaded)
    );

    inst_load_ctrl #(.INST_MEM_WIDTH(2)) u_dut_small (
        .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(b_rx_ready),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr[1:0]), .fetch_grant(b_fetch_grant),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .cpu_run(b_cpu_run), .load_err(b_load_err), .words_loaded(b_words_loaded)
    );

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (reset) begin
            if (mem_we) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
                last_wr_cyc = cyc;
            end
            if (cpu_run && !run_seen) begin
                run_seen = 1'b1;
                run_cyc  = cyc;
            end
            if (fetch_grant && !cpu_run) grant_bad++;
        end
    end

    task automatic do_reset();
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; fetch_req = 1'b0; fetch_addr = 14'd0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1;
        wr_addr_q.delete(); wr_data_q.delete();
        run_seen = 1'b0; run_cyc = 0; last_wr_cyc = 0; grant_bad = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int g;
        g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        repeat (g) begin
            rx_valid = 1'b0;
            @(posedge CLK); #1;
        end
        rx_valid = 1'b1; rx_data = b;
        @(posedge CLK); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gapmax);
    endtask

    task automatic send_image(input int gapmax);
        logic [31:0] sum;
        sum = 32'(img.size());
        send_word(sum, gapmax);
        foreach (img[i]) begin
            send_word(img[i], gapmax);
            sum = sum + img[i];
        end
`ifdef INST_LOAD_CHECKSUM_EN
        send_word(sum, gapmax);
`endif
    endtask

    task automatic check_writes(input string tag);
        checks++;
        if (wr_data_q.size() !== exp_data.size()) begin
            errors++;
            $display("FAIL %s_write_count: got %0d want %0d", tag, wr_data_q.size(), exp_data.size());
        end
        foreach (exp_data[i]) begin
            if (i < wr_data_q.size()) begin
                checks++;
                if (wr_addr_q[i] !== 14'(i)) begin
                    errors++;
                    $display("FAIL %s_addr%0d: got %0d want %0d", tag, i, wr_addr_q[i], i);
                end
                checks++;
                if (wr_data_q[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL %s_data%0d: got %h want %h", tag, i, wr_data_q[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        fetch_req = 1'b1; fetch_addr = 14'd9;
        #1;
        checks++; if (rx_ready !== 1'b1)      begin errors++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        checks++; if (mem_we !== 1'b0)        begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 14'd0)     begin errors++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0)    begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (fetch_grant !== 1'b0)   begin errors++; $display("FAIL reset_fetch_grant: got %b want 0", fetch_grant); end
        checks++; if (cpu_run !== 1'b0)       begin errors++; $display("FAIL reset_cpu_run: got %b want 0", cpu_run); end
        checks++; if (load_err !== 1'b0)      begin errors++; $display("FAIL reset_load_err: got %b want 0", load_err); end
        checks++; if (words_loaded !== 15'd0) begin errors++; $display("FAIL reset_words_loaded: got %0d want 0", words_loaded); end
        fetch_req = 1'b0;
    endtask

    task automatic test_three_words();
        do_reset();
        img = '{32'h20010005, 32'h00000000, 32'hFFFFFFFF};
        exp_data = img;
        send_image(0);
        repeat (3) @(posedge CLK);
        #1;
        check_writes("three");
        checks++; if (words_loaded !== 15'd3) begin errors++; $display("FAIL three_words_loaded: got %0d want 3", words_loaded); end
        checks++; if (cpu_run !== 1'b1)       begin errors++; $display("FAIL three_cpu_run: got %b want 1", cpu_run); end
        checks++; if (rx_ready !== 1'b0)      begin errors++; $display("FAIL three_rx_ready: got %b want 0", rx_ready); end
        checks++;
        if (run_cyc !== last_wr_cyc + RUN_LAT) begin
            errors++; $display("FAIL three_run_latency: got %0d want %0d", run_cyc - last_wr_cyc, RUN_LAT);
        end
    endtask

    task automatic test_zero_words();
        do_reset();
        img = {};
        exp_data = {};
        send_image(0);
        repeat (2) @(posedge CLK);
        #1;
        check_writes("zero");
        checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL zero_cpu_run: got %b want 1", cpu_run); end
        fetch_req = 1'b1; fetch_addr = 14'd5;
        #1;
        checks++; if (fetch_grant !== 1'b1) begin errors++; $display("FAIL zero_fetch_grant: got %b want 1", fetch_grant); end
        checks++; if (mem_addr !== 14'd5)   begin errors++; $display("FAIL zero_mem_addr: got %0d want 5", mem_addr); end
        checks++; if (mem_we !== 1'b0)      begin errors++; $display("FAIL zero_mem_we: got %b want 0", mem_we); end
        fetch_req = 1'b0;
    endtask

    task automatic test_gaps();
        do_reset();
        fetch_req = 1'b1; fetch_addr = 14'd7;
        img = '{32'h12345678, 32'hA5A5A5A5};
        exp_data = img;
        send_image(3);
        fetch_req = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_writes("gaps");
        checks++; if (grant_bad !== 0)        begin errors++; $display("FAIL gaps_grant_during_load: got %0d want 0", grant_bad); end
        checks++; if (words_loaded !== 15'd2) begin errors++; $display("FAIL gaps_words_loaded: got %0d want 2", words_loaded); end
        checks++; if (cpu_run !== 1'b1)       begin errors++; $display("FAIL gaps_cpu_run: got %b want 1", cpu_run); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        send_word(32'd3, 0);
        send_word(32'h11111111, 0);
        send_byte(8'h22, 0);
        send_byte(8'h22, 0);
        do_reset();
        img = '{32'hCAFEF00D};
        exp_data = img;
        send_image(0);
        repeat (3) @(posedge CLK);
        #1;
        check_writes("midreset");
        checks++; if (words_loaded !== 15'd1) begin errors++; $display("FAIL midreset_words_loaded: got %0d want 1", words_loaded); end
    endtask

    task automatic test_small_mem();
        do_reset();
        img = '{32'h1, 32'h2, 32'h3, 32'h4};
        send_image(0);
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (b_words_loaded !== 3'd4) begin errors++; $display("FAIL full_words_loaded: got %0d want 4", b_words_loaded); end
        checks++; if (b_cpu_run !== 1'b1)      begin errors++; $display("FAIL full_cpu_run: got %b want 1", b_cpu_run); end
        checks++; if (b_load_err !== 1'b0)     begin errors++; $display("FAIL full_load_err: got %b want 0", b_load_err); end
        do_reset();
        send_word(32'd5, 0);
        send_word(32'h0, 0);
        repeat (2) @(posedge CLK);
        fetch_req = 1'b1;
        #1;
        checks++; if (b_load_err !== 1'b1)    begin errors++; $display("FAIL over_load_err: got %b want 1", b_load_err); end
        checks++; if (b_rx_ready !== 1'b0)    begin errors++; $display("FAIL over_rx_ready: got %b want 0", b_rx_ready); end
        checks++; if (b_cpu_run !== 1'b0)     begin errors++; $display("FAIL over_cpu_run: got %b want 0", b_cpu_run); end
        checks++; if (b_fetch_grant !== 1'b0) begin errors++; $display("FAIL over_fetch_grant: got %b want 0", b_fetch_grant); end
        fetch_req = 1'b0;
    endtask

`ifdef INST_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        send_word(32'd1, 0);
        send_word(32'h00000010, 0);
        send_word(32'h00000011, 0);
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (cpu_run !== 1'b1)  begin errors++; $display("FAIL csum_good_cpu_run: got %b want 1", cpu_run); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL csum_good_load_err: got %b want 0", load_err); end
        do_reset();
        send_word(32'd1, 0);
        send_word(32'h00000010, 0);
        send_word(32'h00000012, 0);
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL csum_bad_load_err: got %b want 1", load_err); end
        checks++; if (cpu_run !== 1'b0)  begin errors++; $display("FAIL csum_bad_cpu_run: got %b want 0", cpu_run); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL csum_bad_rx_ready: got %b want 0", rx_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_three_words();
        test_zero_words();
        test_gaps();
        test_reset_mid_load();
        test_small_mem();
`ifdef INST_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
